pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the single-issue MIPS core. Owns the architectural PC and
//  computes next PC: sequential, beq/bne target, j/jal target or jr register.
//  Runs the fetch handshake with instruction memory; honours hazard-unit stalls and halt.
//  Sits between control/branch unit and instruction memory; replaces free-running PC update.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  TRAP_PC     32'h0000_0080  misaligned-target trap vector (used only with PCSEQ_ALIGN_TRAP_EN)
//  MAX_WAIT    16             imem wait cycles before timeout flag; 0 disables the check
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   synchronous, active-high
//  stall         in   1   hazard unit: hold PC, do not issue new fetch
//  halt          in   1   stop sequencing after the current fetch completes
//  branch_taken  in   1   conditional branch resolved taken
//  branch_imm    in   16  branch offset, word-granular, signed
//  jump          in   1   j/jal request
//  jump_target   in   26  instr_index field
//  jr            in   1   jr request
//  jr_addr       in   32  register-file value for jr
//  imem_ack      in   1   instruction memory: data for imem_addr valid this cycle
//  imem_req      out  1   fetch request
//  imem_addr     out  32  fetch address (= pc)
//  pc            out  32  current architectural PC
//  pc_plus4      out  32  pc + 4 (link value for jal)
//  fetch_valid   out  1   one-cycle pulse: instruction at pc accepted
//  halted        out  1   sequencer stopped
//  timeout       out  1   sticky: imem_ack absent for MAX_WAIT cycles
//  trap          out  1   one-cycle pulse: misaligned redirect taken to TRAP_PC
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_IDLE, imem_req=0, fetch_valid=0, halted=0, timeout=0, trap=0,
//   pending redirect cleared. Reset mid-fetch abandons the request; late imem_ack is ignored.
//  FSM states: S_IDLE, S_REQ, S_HOLD, S_HALT.
//   S_IDLE: one cycle after reset deasserts -> S_REQ.
//   S_REQ: imem_req=1, imem_addr=pc held stable until imem_ack.
//    On ack: fetch_valid=1 same cycle; stall=0 -> pc<=next_pc, stay S_REQ (new address next cycle);
//    stall=1 -> S_HOLD (pc unchanged); halt=1 overrides both -> S_HALT, pc<=next_pc.
//   S_HOLD: imem_req=0; stall falls -> pc<=next_pc, S_REQ; halt=1 -> S_HALT.
//   S_HALT: halted=1, imem_req=0; only reset leaves.
//  Throughput: zero-wait memory gives one fetch per cycle (ack same cycle as req).
//  Redirect priority: jr > jump > branch_taken > sequential.
//   branch target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00} (32-bit, wraps mod 2^32).
//   jump target   = {pc_plus4[31:28], jump_target, 2'b00}.
//   jr target     = jr_addr.
//  Redirect inputs are single-cycle pulses; any pulse arriving while no PC update occurs
//   is captured in a pending register (higher priority overwrites lower, never vice versa).
//   Redirect and pending both present at update: higher priority wins; pending cleared on update.
//  pc_plus4 = pc + 4, wraps 32'hFFFF_FFFC -> 0.
//  timeout: counter runs while S_REQ and !imem_ack, clears on ack; sets sticky at MAX_WAIT.
// CONFIGURATION
//  PCSEQ_ALIGN_TRAP_EN defined: selected jr target with addr[1:0]!=0 -> pc<=TRAP_PC, trap pulse.
//  Not defined: low two bits of every target forced to 2'b00; trap tied 0.
// STRUCTURE
//  Package pc_seq_pkg: state enum (S_IDLE..S_HALT), redirect-kind encoding (RD_NONE,
//   RD_BRANCH, RD_JUMP, RD_JR), default RESET_PC/TRAP_PC constants.
//  Sub-module pc_target_calc: combinational branch/jump/jr target + priority mux.
//  FSM, pending register and timeout counter stay in pc_sequencer.
// TESTING
//  Reset, zero-wait ack 4 cycles -> imem_addr 0,4,8,C; fetch_valid high each cycle.
//  pc=0x100, branch_taken imm=16'hFFFE -> next pc=0xFC; imm=16'h0003 -> 0x110.
//  pc=0x3000_0010 jump target=26'h0000040 -> pc=0x3000_0100; jr+jump together -> jr wins.
//  jr 0x200 pulsed during 3-cycle ack wait -> captured; after ack pc=0x200.
//  stall 2 cycles after ack -> pc frozen, imem_req=0; then resumes; halt -> halted=1, no req.
//  Align trap (macro on): jr_addr=0x203 -> pc=0x80, trap=1; macro off -> pc=0x200.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Holds the FSM state encoding, the redirect-kind encoding (ordered by priority,
// so a plain magnitude compare picks the winner) and the default vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // Numeric order is priority order: RD_JR > RD_JUMP > RD_BRANCH > RD_NONE.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2,
        RD_JR     = 2'd3
    } redirect_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0080;

    // Clear the byte-offset bits so the PC always stays word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target calculation and priority selection.
// Computes branch / jump / jr targets from the current-cycle request pulses,
// picks the highest-priority one, then merges it with any redirect already
// held pending (the higher priority of the two wins).
module pc_target_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  redirect_t   pend_kind,
    input  logic [31:0] pend_target,
    output redirect_t   sel_kind,
    output logic [31:0] sel_target
);

    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    redirect_t   new_kind;
    logic [31:0] new_target;

    // Raw targets: branch offset is word-granular and wraps mod 2^32.
    assign branch_addr = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_addr   = {pc_plus4[31:28], jump_target, 2'b00};

    // Priority mux among this cycle's requests, then against the pending one.
    always_comb begin
        new_kind   = RD_NONE;
        new_target = 32'd0;
        if (jr) begin
            new_kind   = RD_JR;
            new_target = jr_addr;
        end else if (jump) begin
            new_kind   = RD_JUMP;
            new_target = jump_addr;
        end else if (branch_taken) begin
            new_kind   = RD_BRANCH;
            new_target = branch_addr;
        end

        if (pend_kind > new_kind) begin
            sel_kind   = pend_kind;
            sel_target = pend_target;
        end else begin
            sel_kind   = new_kind;
            sel_target = new_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the architectural PC, runs the instruction-fetch
// handshake, honours stall/halt, holds pending redirects and watches for a
// missing imem_ack.
// Optional feature macro: PCSEQ_ALIGN_TRAP_EN (misaligned jr target traps to
// TRAP_PC); when undefined all targets are forced word aligned and trap is 0.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        timeout,
    output logic        trap
);

    localparam logic [16:0] WAIT_LIMIT = 17'(MAX_WAIT);
    localparam bit          WAIT_CHECK = (MAX_WAIT != 0);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4_c;
    redirect_t   pend_kind_reg;
    logic [31:0] pend_target_reg;
    redirect_t   sel_kind;
    logic [31:0] sel_target;
    logic [31:0] redirect_pc;
    logic        misaligned;
    logic        pc_update;
    logic        req_c;
    logic        fetch_c;
    logic [15:0] wait_cnt_reg;
    logic        timeout_reg;
    logic        trap_reg;

    assign pc_plus4_c = pc_reg + 32'd4;

    pc_target_calc u_target_calc (
        .pc_plus4     (pc_plus4_c),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .pend_kind    (pend_kind_reg),
        .pend_target  (pend_target_reg),
        .sel_kind     (sel_kind),
        .sel_target   (sel_target)
    );

`ifdef PCSEQ_ALIGN_TRAP_EN
    // Only a jr can produce a misaligned target; such a redirect vectors to TRAP_PC.
    assign misaligned  = (sel_kind == RD_JR) && (sel_target[1:0] != 2'b00);
    assign redirect_pc = misaligned ? TRAP_PC : sel_target;
`else
    logic unused_trap_pc;
    assign unused_trap_pc = ^TRAP_PC;
    assign misaligned     = 1'b0;
    assign redirect_pc    = word_align(sel_target);
`endif

    assign pc_next = (sel_kind == RD_NONE) ? pc_plus4_c : redirect_pc;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state, handshake outputs and the PC-advance decision.
    always_comb begin
        state_next = state_reg;
        req_c      = 1'b0;
        fetch_c    = 1'b0;
        pc_update  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    fetch_c = 1'b1;
                    if (halt) begin
                        state_next = S_HALT;
                        pc_update  = 1'b1;
                    end else if (stall) begin
                        state_next = S_HOLD;
                    end else begin
                        pc_update  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (halt) begin
                    state_next = S_HALT;
                    pc_update  = 1'b1;
                end else if (!stall) begin
                    state_next = S_REQ;
                    pc_update  = 1'b1;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // A request in flight when reset arrives is abandoned immediately.
        if (reset) begin
            req_c     = 1'b0;
            fetch_c   = 1'b0;
            pc_update = 1'b0;
        end
    end

    // PC register, pending-redirect capture and the one-cycle trap pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            pend_kind_reg   <= RD_NONE;
            pend_target_reg <= 32'd0;
            trap_reg        <= 1'b0;
        end else begin
            trap_reg <= pc_update && misaligned;
            if (pc_update) begin
                pc_reg          <= pc_next;
                pend_kind_reg   <= RD_NONE;
                pend_target_reg <= 32'd0;
            end else begin
                // sel_* already keeps the higher of pending vs. new request.
                pend_kind_reg   <= sel_kind;
                pend_target_reg <= sel_target;
            end
        end
    end

    // Wait counter for an outstanding fetch; timeout flag is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_reg <= 16'd0;
            timeout_reg  <= 1'b0;
        end else if ((state_reg == S_REQ) && !imem_ack) begin
            if (wait_cnt_reg != 16'hFFFF) begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
            if (WAIT_CHECK && ((17'(wait_cnt_reg) + 17'd1) >= WAIT_LIMIT)) begin
                timeout_reg <= 1'b1;
            end
        end else begin
            wait_cnt_reg <= 16'd0;
        end
    end

    assign imem_req    = req_c;
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = pc_plus4_c;
    assign fetch_valid = fetch_c;
    assign halted      = (state_reg == S_HALT) && !reset;
    assign timeout     = timeout_reg;
    assign trap        = trap_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Expected fetch addresses are queued
// when an ack is driven and checked by a monitor whenever fetch_valid fires.
// Honours PCSEQ_ALIGN_TRAP_EN for the misaligned-jr expectation.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        timeout;
    logic        trap;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

`ifdef PCSEQ_ALIGN_TRAP_EN
    localparam logic [31:0] EXP_MIS_PC = 32'h0000_0080;
    localparam logic        EXP_TRAP   = 1'b1;
`else
    localparam logic [31:0] EXP_MIS_PC = 32'h0000_0200;
    localparam logic        EXP_TRAP   = 1'b0;
`endif

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .halt         (halt),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .imem_ack     (imem_ack),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .timeout      (timeout),
        .trap         (trap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: every accepted fetch must match the oldest expectation.
    always @(negedge clock) begin
        if (fetch_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: fetch_valid=1 at imem_addr=%08h, none expected", imem_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("[TB] fetch addr=%08h expected=%08h", imem_addr, mon_exp);
                if (imem_addr !== mon_exp) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %08h, expected %08h", imem_addr, mon_exp);
                end
            end
        end
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Drive one acked fetch with whatever redirect inputs the caller set up.
    task automatic issue_ack(input logic [31:0] exp_addr);
        imem_ack = 1'b1;
        exp_q.push_back(exp_addr);
        next_cycle();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        imem_ack = 1'b1;
        next_cycle();
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || fetch_valid !== 1'b0 ||
            halted !== 1'b0 || timeout !== 1'b0 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%08h req=%b fv=%b halted=%b timeout=%b trap=%b, expected 0s",
                     pc, imem_req, fetch_valid, halted, timeout, trap);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_late_ack: req=%b fv=%b, expected 0 0", imem_req, fetch_valid);
        end
        next_cycle();
        imem_ack = 1'b0;
        @(negedge clock);
        n_tests++;
        $display("[TB] reset done: req=%b addr=%08h", imem_req, imem_addr);
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%08h, expected 1 00000000", imem_req, imem_addr);
        end
        next_cycle();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            issue_ack(32'(i * 4));
        end
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h10) begin
            n_fail++;
            $display("FAIL seq_pc: got %08h, expected 00000010", pc);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        jr = 1'b1; jr_addr = 32'h100;
        issue_ack(32'h10);
        branch_taken = 1'b1; branch_imm = 16'hFFFE;
        issue_ack(32'h100);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'hFC) begin
            n_fail++;
            $display("FAIL branch_back: got %08h, expected 000000fc", pc);
        end
        next_cycle();
        jr = 1'b1; jr_addr = 32'h100;
        issue_ack(32'hFC);
        branch_taken = 1'b1; branch_imm = 16'h0003;
        issue_ack(32'h100);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h110) begin
            n_fail++;
            $display("FAIL branch_fwd: got %08h, expected 00000110", pc);
        end
        next_cycle();
    endtask

    task automatic test_jump();
        jr = 1'b1; jr_addr = 32'h3000_0010;
        issue_ack(32'h110);
        jump = 1'b1; jump_target = 26'h0000040;
        issue_ack(32'h3000_0010);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h3000_0100) begin
            n_fail++;
            $display("FAIL jump_target: got %08h, expected 30000100", pc);
        end
        next_cycle();
        jr = 1'b1; jr_addr = 32'h400;
        jump = 1'b1; jump_target = 26'h0000040;
        branch_taken = 1'b1; branch_imm = 16'h0010;
        issue_ack(32'h3000_0100);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h400) begin
            n_fail++;
            $display("FAIL jr_priority: got %08h, expected 00000400", pc);
        end
        next_cycle();
    endtask

    task automatic test_pending();
        jr = 1'b1; jr_addr = 32'h200;
        next_cycle();
        jr = 1'b0;
        branch_taken = 1'b1; branch_imm = 16'h0005;
        @(negedge clock);
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL wait_hold_addr: req=%b addr=%08h, expected 1 00000400", imem_req, imem_addr);
        end
        next_cycle();
        branch_taken = 1'b0;
        next_cycle();
        issue_ack(32'h400);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h200) begin
            n_fail++;
            $display("FAIL pending_jr: got %08h, expected 00000200", pc);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        issue_ack(32'h200);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_tests++;
            if (imem_req !== 1'b0 || pc !== 32'h200) begin
                n_fail++;
                $display("FAIL stall_hold: req=%b pc=%08h, expected 0 00000200", imem_req, pc);
            end
            next_cycle();
        end
        stall = 1'b0;
        next_cycle();
        @(negedge clock);
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
            n_fail++;
            $display("FAIL stall_resume: req=%b addr=%08h, expected 1 00000204", imem_req, imem_addr);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        issue_ack(32'h204);
        repeat (15) next_cycle();
        @(negedge clock);
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got %b after 15 waits, expected 0", timeout);
        end
        next_cycle();
        @(negedge clock);
        n_tests++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_set: got %b after 16 waits, expected 1", timeout);
        end
        next_cycle();
        issue_ack(32'h208);
        @(negedge clock);
        n_tests++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b after ack, expected 1", timeout);
        end
        next_cycle();
    endtask

    task automatic test_halt();
        halt = 1'b1; stall = 1'b1;
        issue_ack(32'h20C);
        @(negedge clock);
        n_tests++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h210) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b req=%b pc=%08h, expected 1 0 00000210", halted, imem_req, pc);
        end
        next_cycle();
        imem_ack = 1'b1;
        @(negedge clock);
        n_tests++;
        if (fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_no_fetch: fetch_valid=%b, expected 0", fetch_valid);
        end
        next_cycle();
        imem_ack = 1'b0; halt = 1'b0; stall = 1'b0;
        next_cycle();
        @(negedge clock);
        n_tests++;
        if (halted !== 1'b1 || pc !== 32'h210) begin
            n_fail++;
            $display("FAIL halt_stays: halted=%b pc=%08h, expected 1 00000210", halted, pc);
        end
        next_cycle();
    endtask

    task automatic test_align();
        test_reset();
        jr = 1'b1; jr_addr = 32'h203;
        issue_ack(32'h0);
        @(negedge clock);
        n_tests++;
        if (pc !== EXP_MIS_PC || trap !== EXP_TRAP) begin
            n_fail++;
            $display("FAIL misaligned_jr: pc=%08h trap=%b, expected %08h %b", pc, trap, EXP_MIS_PC, EXP_TRAP);
        end
        next_cycle();
        @(negedge clock);
        n_tests++;
        if (trap !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_pulse: trap=%b one cycle later, expected 0", trap);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        branch_taken = 1'b1; branch_imm = 16'h0001;
        next_cycle();
        branch_taken = 1'b0;
        jump = 1'b1; jump_target = 26'h0000123;
        next_cycle();
        jump = 1'b0;
        branch_taken = 1'b1; branch_imm = 16'h0002;
        issue_ack(EXP_MIS_PC);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h48C) begin
            n_fail++;
            $display("FAIL pending_overwrite: got %08h, expected 0000048c", pc);
        end
        next_cycle();
        branch_taken = 1'b1; branch_imm = 16'h0001;
        next_cycle();
        branch_taken = 1'b0;
        jr = 1'b1; jr_addr = 32'h600;
        issue_ack(32'h48C);
        @(negedge clock);
        n_tests++;
        if (pc !== 32'h600) begin
            n_fail++;
            $display("FAIL new_beats_pending: got %08h, expected 00000600", pc);
        end
        next_cycle();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; branch_imm = 16'h0;
        jump = 1'b0; jump_target = 26'h0;
        jr = 1'b0; jr_addr = 32'h0; imem_ack = 1'b0;
        next_cycle();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_pending();
        test_stall();
        test_timeout();
        test_halt();
        test_align();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fetch_missing: %0d expected fetches never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
